// File: rtl/ascon_pack.sv
// Shared ASCON definitions: round-sequencer state type, round bounds and the
// p_c round-constant table indexed by the sequencer's round number.
package ascon_pack;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } type_seq_state;

   localparam logic [3:0] LAST_ROUND    = 4'd11;
   localparam logic [3:0] START_ROUND_A = 4'd0;

   function automatic logic [7:0] round_constant(input logic [3:0] round);
      logic [7:0] rc;
      case (round)
         4'd0:    rc = 8'hf0;
         4'd1:    rc = 8'he1;
         4'd2:    rc = 8'hd2;
         4'd3:    rc = 8'hc3;
         4'd4:    rc = 8'hb4;
         4'd5:    rc = 8'ha5;
         4'd6:    rc = 8'h96;
         4'd7:    rc = 8'h87;
         4'd8:    rc = 8'h78;
         4'd9:    rc = 8'h69;
         4'd10:   rc = 8'h5a;
         4'd11:   rc = 8'h4b;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

endpackage

// File: rtl/sequenceur_rondes_if.sv
// Handshake and datapath-control bundle between the control FSM (master)
// and the round sequencer (slave).
interface sequenceur_rondes_if;

   logic       start_i;
   logic       mode_i;
   logic [3:0] round_o;
   logic       en_state_o;
   logic       sel_init_o;
   logic       busy_o;
   logic       done_o;

   modport master (
      output start_i,
      output mode_i,
      input  round_o,
      input  en_state_o,
      input  sel_init_o,
      input  busy_o,
      input  done_o
   );

   modport slave (
      input  start_i,
      input  mode_i,
      output round_o,
      output en_state_o,
      output sel_init_o,
      output busy_o,
      output done_o
   );

endinterface

// File: rtl/sequenceur_rondes.sv
// Round sequencer for the iterative ASCON permutation: runs p^a or p^b one
// round per cycle, feeding round_o to p_c and strobing the state register.
//
// state | meaning
// IDLE  | waiting for start_i; round_o = 0, all strobes low
// RUN   | one round per cycle, state register loads every cycle
// DONE  | one-cycle done_o pulse, result stable in the state register
module sequenceur_rondes
   import ascon_pack::*;
#(
   parameter int NB_ROUNDS_A = 12,
   parameter int NB_ROUNDS_B = 6
) (
   input  logic                  clock_i,
   input  logic                  resetb_i,
   sequenceur_rondes_if.slave    bus
);

   // Both modes end on LAST_ROUND, so the start round is derived from the count.
   localparam logic [3:0] START_A = 4'(int'(START_ROUND_A) + 12 - NB_ROUNDS_A);
   localparam logic [3:0] START_B = 4'(int'(LAST_ROUND) + 1 - NB_ROUNDS_B);

   type_seq_state state_q, state_d;
   logic [3:0]    round_q, round_d;
   logic          mode_q, mode_d;
   logic [3:0]    start_round;

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state_q <= IDLE;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               state_d = RUN;
               mode_d  = bus.mode_i;
            end
         end
         RUN: begin
            if (round_q == LAST_ROUND) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) round_q <= 4'd0;
      else           round_q <= round_d;
   end

   always_comb begin
      round_d = round_q;
      case (state_q)
         IDLE: begin
            if (bus.start_i) round_d = bus.mode_i ? START_B : START_A;
            else             round_d = 4'd0;
         end
         RUN: begin
            if (round_q != LAST_ROUND) round_d = round_q + 4'd1;
         end
         DONE:    round_d = 4'd0;
         default: round_d = 4'd0;
      endcase
   end

   // Uses the latched mode so a late mode_i change cannot re-select the input.
   assign start_round    = mode_q ? START_B : START_A;

   assign bus.round_o    = round_q;
   assign bus.en_state_o = (state_q == RUN);
   assign bus.sel_init_o = (state_q == RUN) && (round_q == start_round);
   assign bus.busy_o     = (state_q != IDLE);
   assign bus.done_o     = (state_q == DONE);

endmodule

// File: tb/tb_sequenceur_rondes.sv
// Bench for sequenceur_rondes: default p^b length and NB_ROUNDS_B = 8 side by
// side, each against a queue of expected per-cycle output tuples.
module tb_sequenceur_rondes;

   typedef logic [7:0] seq_t[$];

   logic clk;
   logic resetb;
   logic start;
   logic mode;

   int n_cmp = 0;
   int n_err = 0;

   seq_t q6;
   seq_t q8;

   sequenceur_rondes_if if_6 ();
   sequenceur_rondes_if if_8 ();

   assign if_6.start_i = start;
   assign if_6.mode_i  = mode;
   assign if_8.start_i = start;
   assign if_8.mode_i  = mode;

   sequenceur_rondes #(.NB_ROUNDS_A(12), .NB_ROUNDS_B(6)) dut_6 (
      .clock_i  (clk),
      .resetb_i (resetb),
      .bus      (if_6)
   );

   sequenceur_rondes #(.NB_ROUNDS_A(12), .NB_ROUNDS_B(8)) dut_8 (
      .clock_i  (clk),
      .resetb_i (resetb),
      .bus      (if_8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Tuple layout: {round[3:0], en_state, sel_init, busy, done}
   function automatic seq_t build(input int nb_b, input logic m);
      seq_t s;
      int   st;
      st = m ? (12 - nb_b) : 0;
      for (int r = st; r <= 11; r++)
         s.push_back({4'(r), 1'b1, (r == st), 1'b1, 1'b0});
      s.push_back({4'd11, 4'b0011});
      return s;
   endfunction

   function automatic logic [7:0] obs6();
      return {if_6.round_o, if_6.en_state_o, if_6.sel_init_o, if_6.busy_o, if_6.done_o};
   endfunction

   function automatic logic [7:0] obs8();
      return {if_8.round_o, if_8.en_state_o, if_8.sel_init_o, if_8.busy_o, if_8.done_o};
   endfunction

   task automatic tick();
      @(posedge clk);
      if (resetb) begin
         if (q6.size() == 0) begin
            if (start) q6 = build(6, mode);
         end else begin
            void'(q6.pop_front());
         end
         if (q8.size() == 0) begin
            if (start) q8 = build(8, mode);
         end else begin
            void'(q8.pop_front());
         end
      end
      #1;
      chk("dut6_outputs", 32'(obs6()), 32'((q6.size() != 0) ? q6[0] : 8'h00));
      chk("dut8_outputs", 32'(obs8()), 32'((q8.size() != 0) ? q8[0] : 8'h00));
      @(negedge clk);
   endtask

   initial begin
      int  n;
      logic prev_busy;

      resetb = 1'b0;
      start  = 1'b0;
      mode   = 1'b0;
      #12;
      chk("reset_dut6", 32'(obs6()), 32'h0);
      chk("reset_dut8", 32'(obs8()), 32'h0);
      @(negedge clk);
      resetb = 1'b1;
      repeat (2) tick();

      // p^a single start pulse
      start = 1'b1; mode = 1'b0;
      tick();
      start = 1'b0;
      repeat (15) tick();

      // p^b single start pulse
      start = 1'b1; mode = 1'b1;
      tick();
      start = 1'b0;
      repeat (11) tick();

      // start held and mode toggled throughout: nothing queued, restarts from IDLE
      start = 1'b1;
      for (int i = 0; i < 40; i++) begin
         mode = 1'(($urandom >> 3) & 1);
         tick();
      end
      start = 1'b0;
      repeat (16) tick();

      // asynchronous reset while round_o = 4
      start = 1'b1; mode = 1'b0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 20 && if_6.round_o != 4'd4; i++) tick();
      chk("reach_round4", 32'(if_6.round_o), 32'd4);
      #2;
      resetb = 1'b0;
      #1;
      chk("async_rst_dut6", 32'(obs6()), 32'h0);
      chk("async_rst_dut8", 32'(obs8()), 32'h0);
      q6.delete();
      q8.delete();
      start = 1'b1;
      repeat (2) tick();
      resetb = 1'b1;
      start  = 1'b0;
      repeat (5) tick();

      // back-to-back p^a then p^b with start held high
      start = 1'b1; mode = 1'b0;
      tick();
      mode = 1'b1;
      prev_busy = if_6.busy_o;
      n = 0;
      for (int i = 1; i < 40; i++) begin
         tick();
         if (if_6.busy_o && !prev_busy) begin
            n = i;
            break;
         end
         prev_busy = if_6.busy_o;
      end
      chk("start_spacing", 32'(n), 32'd14);
      start = 1'b0;
      repeat (12) tick();

      // random traffic
      for (int i = 0; i < 800; i++) begin
         start = (($urandom % 3) == 0);
         mode  = 1'($urandom % 2);
         tick();
      end
      start = 1'b0;
      repeat (16) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sequenceur_rondes.md
# sequenceur_rondes

Round sequencer driving the ASCON permutation datapath: it generates the round number consumed by the constant-addition stage (p_c) and the control strobes for the 320-bit state register. It sits between the top-level control FSM and the iterative permutation (p_c → p_s → p_l, one round per cycle). It runs either p^a (12 rounds, constants 0..11) or p^b (NB_ROUNDS_B rounds, ending on constant 11), with a start/done handshake.

## Interface
- NB_ROUNDS_A, 12, round count of p^a; fixed at 12.
- NB_ROUNDS_B, 6, round count of p^b; legal range 1..12.
- clock_i  in  1  system clock, rising edge.
- resetb_i  in  1  reset; one clock, asynchronous, active-low.
- start_i  in  1  request a permutation; sampled only in IDLE.
- mode_i  in  1  0 = p^a, 1 = p^b; captured when start_i is accepted.
- round_o  out  4  round number to p_c (index into round_constant).
- en_state_o  out  1  state-register load enable.
- sel_init_o  out  1  1 = permutation input taken from the external state, 0 = feedback.
- busy_o  out  1  high while a permutation is in progress.
- done_o  out  1  one-cycle pulse; permutation result valid in the state register.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Outputs en/sel/busy/done = 0; round_o holds 0.
  - When start_i = 1, go to RUN and load round_o with the start round: 0 for mode 0, 12 − NB_ROUNDS_B for mode 1 (6 by default). Latch mode_i.
- RUN:
  - en_state_o = 1, busy_o = 1.
  - sel_init_o = 1 only on the first RUN cycle (round_o = start round), otherwise 0.
  - Each edge increments round_o.
  - When round_o = 11, go to DONE instead of incrementing; round_o holds 11.
- DONE:
  - done_o = 1, busy_o = 1, en_state_o = 0. round_o holds 11.
  - Next edge: go to IDLE and clear round_o to 0.
- start_i is ignored in RUN and DONE and is not queued. After the DONE cycle, the sequencer needs start_i in IDLE to begin again.
- mode_i changes after acceptance have no effect on the run in progress.
- round_o never exceeds 11 and never wraps; 4-bit unsigned arithmetic.
- Reset, asserted at any time including mid-RUN:
  - FSM goes to IDLE; round_o = 0; all 1-bit outputs = 0.
  - The partially permuted state is abandoned.
  - Operation restarts only on a fresh start_i after resetb_i is released.

## Timing
- All outputs are registered or decoded from registered state. No combinational path from start_i or mode_i to any output.
- start_i accepted at edge E0 → first RUN cycle between E0 and E1.
- p^a: RUN for 12 cycles (round_o = 0..11); done_o is high in cycle 13 after acceptance.
- p^b (default): RUN for 6 cycles (round_o = 6..11); done_o in cycle 7. In general, done_o comes in cycle NB_ROUNDS_B + 1.
- The state register captures round r at the edge ending the RUN cycle where round_o = r. The final result is stable from the DONE cycle onward.
- Minimum start-to-start spacing: p^a 14 cycles, p^b NB_ROUNDS_B + 2 cycles. IDLE must last at least one cycle.

## Structure
- Shared package ascon_pack gains:
  - FSM state enum type_seq_state {IDLE, RUN, DONE}.
  - Constants LAST_ROUND = 4'd11, START_ROUND_A = 4'd0.
  - round_constant (already in ascon_pack) stays indexed by round_o.
- No sub-module. FSM and round counter are one process each in the same module. A counter sub-module is not warranted for a 4-bit load/increment.

## Test plan
- p^a: reset, then start_i = 1 with mode_i = 0 for one cycle → round_o = 0,1,…,11 on 12 consecutive cycles. sel_init_o = 1 only on round 0; en_state_o = 1 throughout. Then done_o = 1 for exactly one cycle, then IDLE with round_o = 0.
- p^b: start_i with mode_i = 1 → round_o = 6..11 (6 cycles), done_o in cycle 7, busy_o high cycles 1–7.
- Ignored inputs: start_i held high and mode_i toggled during RUN and DONE → the sequence is unchanged, with no second run queued. With start_i still high in the following IDLE cycle, a new run starts on the next edge.
- Reset mid-run: resetb_i low asynchronously while round_o = 4 → outputs go to 0 and round_o to 0 immediately, without waiting for a clock edge. After release, there is no activity until start_i.
- Back-to-back runs: p^a then p^b, each started on the first IDLE cycle → spacing is exactly 14 cycles. The p^b round_o sequence is 6..11.
- Parameter: NB_ROUNDS_B = 8 → round_o = 4..11, done_o in cycle 9.
